// File: rtl/mem_write_buffer.sv
// Posted-write buffer between a cache's 128-bit memory master and its interconnect slave port.
// Optional build macro WRBUF_MERGE_EN: same-line writes merge into the youngest queued entry.
module mem_write_buffer #(
    parameter int DEPTH    = 4,
    parameter int LINE_LSB = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            in_address,
    input  logic                   in_read,
    input  logic                   in_write,
    input  logic [127:0]           in_writedata,
    input  logic [15:0]            in_byteenable,
    output logic [127:0]           in_readdata,
    output logic                   in_waitrequest,
    output logic [31:0]            out_address,
    output logic                   out_read,
    output logic                   out_write,
    output logic [127:0]           out_writedata,
    output logic [15:0]            out_byteenable,
    input  logic [127:0]           out_readdata,
    input  logic                   out_waitrequest,
    output logic [$clog2(DEPTH):0] wb_count,
    output logic                   wb_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;

    logic [1:0]    state;
    logic [PW-1:0] wr_ptr, rd_ptr, count;
    logic [AW-1:0] wr_idx, rd_idx;
    logic          full, empty, hit;
    logic          start_read, start_write, pop, read_done, push, merge;
    logic [127:0]  head_data;
    logic [15:0]   head_be;

    logic [31:0]   addr_mem [DEPTH];
    logic [127:0]  data_mem [DEPTH];
    logic [15:0]   be_mem   [DEPTH];

    assign wr_idx   = wr_ptr[AW-1:0];
    assign rd_idx   = rd_ptr[AW-1:0];
    assign count    = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign wb_count = count;
    assign wb_empty = empty;

    // The head entry stays valid while it sits on out_*, so a read to that line still waits.
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, AW'(i) - rd_idx} < count) &&
                (addr_mem[i][31:LINE_LSB] == in_address[31:LINE_LSB]))
                hit = 1'b1;
        end
    end

    // A read that hits or finds the buffer full lets writes drain first, avoiding deadlock.
    assign start_read  = (state == ST_IDLE) && in_read && !hit && !full;
    assign start_write = (state == ST_IDLE) && !start_read && !empty;
    assign pop         = (state == ST_WRITE) && !out_waitrequest;
    assign read_done   = (state == ST_READ) && !out_waitrequest;
    assign push        = in_write && !full && !merge;

`ifdef WRBUF_MERGE_EN
    logic [AW-1:0] young_idx;
    logic [127:0]  merged_data;
    logic [15:0]   merged_be;

    assign young_idx = wr_idx - AW'(1);

    always_comb begin
        merged_data = data_mem[young_idx];
        for (int b = 0; b < 16; b++) begin
            if (in_byteenable[b])
                merged_data[8*b +: 8] = in_writedata[8*b +: 8];
        end
        merged_be = be_mem[young_idx] | in_byteenable;
    end

    // The youngest entry is off limits only once it is already on out_*; a merge in the
    // cycle it is being loaded forwards the merged line straight onto out_*.
    assign merge = in_write && !empty &&
                   (addr_mem[young_idx][31:LINE_LSB] == in_address[31:LINE_LSB]) &&
                   !((state == ST_WRITE) && (count == PW'(1)));
    assign head_data = (merge && count == PW'(1)) ? merged_data : data_mem[rd_idx];
    assign head_be   = (merge && count == PW'(1)) ? merged_be   : be_mem[rd_idx];
`else
    assign merge     = 1'b0;
    assign head_data = data_mem[rd_idx];
    assign head_be   = be_mem[rd_idx];
`endif

    always_comb begin
        in_waitrequest = 1'b1;
        if (rst_n) begin
            if (in_read)
                in_waitrequest = !read_done;
            else if (in_write)
                in_waitrequest = !(push || merge);
        end
    end

    assign in_readdata = read_done ? out_readdata : '0;

    // NOTE: entry storage has no reset; validity comes only from the reset pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_idx] <= in_address;
            data_mem[wr_idx] <= in_writedata;
            be_mem[wr_idx]   <= in_byteenable;
        end
`ifdef WRBUF_MERGE_EN
        if (merge) begin
            data_mem[young_idx] <= merged_data;
            be_mem[young_idx]   <= merged_be;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            out_read       <= 1'b0;
            out_write      <= 1'b0;
            out_address    <= '0;
            out_writedata  <= '0;
            out_byteenable <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_read) begin
                        out_read       <= 1'b1;
                        out_address    <= in_address;
                        out_byteenable <= in_byteenable;
                        state          <= ST_READ;
                    end else if (start_write) begin
                        out_write      <= 1'b1;
                        out_address    <= addr_mem[rd_idx];
                        out_writedata  <= head_data;
                        out_byteenable <= head_be;
                        state          <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (!out_waitrequest) begin
                        out_write <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (!out_waitrequest) begin
                        out_read <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    illegal_read_write: assert property (@(posedge clk) disable iff (!rst_n) !(in_read && in_write));

endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed self-checking bench for mem_write_buffer (DEPTH=4, LINE_LSB=4).
// The merge scenario runs only when WRBUF_MERGE_EN is defined.
module tb_mem_write_buffer;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  in_address;
    logic         in_read;
    logic         in_write;
    logic [127:0] in_writedata;
    logic [15:0]  in_byteenable;
    logic [127:0] in_readdata;
    logic         in_waitrequest;
    logic [31:0]  out_address;
    logic         out_read;
    logic         out_write;
    logic [127:0] out_writedata;
    logic [15:0]  out_byteenable;
    logic [127:0] out_readdata;
    logic         out_waitrequest;
    logic [2:0]   wb_count;
    logic         wb_empty;

    int errors = 0;
    int checks = 0;

    mem_write_buffer #(.DEPTH(4), .LINE_LSB(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_address     (in_address),
        .in_read        (in_read),
        .in_write       (in_write),
        .in_writedata   (in_writedata),
        .in_byteenable  (in_byteenable),
        .in_readdata    (in_readdata),
        .in_waitrequest (in_waitrequest),
        .out_address    (out_address),
        .out_read       (out_read),
        .out_write      (out_write),
        .out_writedata  (out_writedata),
        .out_byteenable (out_byteenable),
        .out_readdata   (out_readdata),
        .out_waitrequest(out_waitrequest),
        .wb_count       (wb_count),
        .wb_empty       (wb_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_write(input logic [31:0] addr, input logic [127:0] data, input logic [15:0] be);
        in_address    = addr;
        in_writedata  = data;
        in_byteenable = be;
        in_write      = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_addr [4];
        int          idx;
        int          wr_seen;

        rst_n           = 1'b0;
        in_address      = '0;
        in_read         = 1'b0;
        in_write        = 1'b0;
        in_writedata    = '0;
        in_byteenable   = '0;
        out_readdata    = '0;
        out_waitrequest = 1'b0;

        // Reset state
        #2;
        check("rst_in_waitrequest", in_waitrequest, 1'b1);
        check("rst_out_write", out_write, 1'b0);
        check("rst_out_read", out_read, 1'b0);
        check("rst_out_address", out_address, 32'h0);
        check("rst_wb_count", wb_count, 3'd0);
        check("rst_wb_empty", wb_empty, 1'b1);
        check("rst_in_readdata", in_readdata, 128'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // Single write drains one cycle after it is queued
        drive_write(32'h1000, 128'h11112222333344445555666677778888, 16'hFFFF);
        #1;
        check("t1_accept_wait", in_waitrequest, 1'b0);
        tick();
        in_write = 1'b0;
        check("t1_count_queued", wb_count, 3'd1);
        check("t1_no_out_write_yet", out_write, 1'b0);
        tick();
        check("t1_out_write", out_write, 1'b1);
        check("t1_out_address", out_address, 32'h1000);
        check("t1_out_writedata", out_writedata, 128'h11112222333344445555666677778888);
        check("t1_out_be", out_byteenable, 16'hFFFF);
        tick();
        check("t1_write_dropped", out_write, 1'b0);
        check("t1_count_drained", wb_count, 3'd0);
        check("t1_empty", wb_empty, 1'b1);

        // Fill to DEPTH with the interconnect stalled; the fifth write must stall
        out_waitrequest = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive_write(32'h100 + 32'(k) * 32'h10, {4{32'h100 + 32'(k) * 32'h10}}, 16'hFFFF);
            #1;
            check("t2_accept", in_waitrequest, 1'b0);
            tick();
        end
        drive_write(32'h140, {4{32'h140}}, 16'hFFFF);
        #1;
        check("t2_full_count", wb_count, 3'd4);
        check("t2_fifth_stalled", in_waitrequest, 1'b1);
        check("t2_head_on_bus", out_address, 32'h100);
        check("t2_head_write", out_write, 1'b1);
        tick();
        tick();
        check("t2_still_stalled", in_waitrequest, 1'b1);
        check("t2_head_held", out_address, 32'h100);
        out_waitrequest = 1'b0;
        #1;
        check("t2_full_stalls_during_pop", in_waitrequest, 1'b1);
        tick();
        check("t2_count_after_pop", wb_count, 3'd3);
        check("t2_fifth_accepted", in_waitrequest, 1'b0);
        tick();
        in_write = 1'b0;
        check("t2_count_refilled", wb_count, 3'd4);
        exp_addr[0] = 32'h110;
        exp_addr[1] = 32'h120;
        exp_addr[2] = 32'h130;
        exp_addr[3] = 32'h140;
        idx = 0;
        for (int c = 0; c < 30 && idx < 4; c++) begin
            if (out_write) begin
                check("t2_drain_address", out_address, exp_addr[idx]);
                check("t2_drain_data", out_writedata, {4{exp_addr[idx]}});
                idx++;
            end
            tick();
        end
        check("t2_drain_total", idx, 4);
        check("t2_empty", wb_empty, 1'b1);

        // A miss read bypasses the queued 0x3000 write
        out_waitrequest = 1'b1;
        drive_write(32'h2000, {4{32'hA2A2A2A2}}, 16'hFFFF);
        tick();
        drive_write(32'h3000, {4{32'hA3A3A3A3}}, 16'hFFFF);
        tick();
        in_write      = 1'b0;
        in_read       = 1'b1;
        in_address    = 32'h4000;
        in_byteenable = 16'hFFFF;
        tick();
        check("t3_read_waits_for_write", out_read, 1'b0);
        check("t3_write_on_bus", out_address, 32'h2000);
        check("t3_read_stalled", in_waitrequest, 1'b1);
        out_waitrequest = 1'b0;
        tick();
        out_waitrequest = 1'b1;
        check("t3_count_one_left", wb_count, 3'd1);
        tick();
        check("t3_out_read", out_read, 1'b1);
        check("t3_read_address", out_address, 32'h4000);
        check("t3_no_write", out_write, 1'b0);
        check("t3_write_still_queued", wb_count, 3'd1);
        check("t3_readdata_masked", in_readdata, 128'h0);
        out_readdata    = 128'hDEADBEEF_00000001_CAFEF00D_12345678;
        out_waitrequest = 1'b0;
        #1;
        check("t3_read_complete_wait", in_waitrequest, 1'b0);
        check("t3_readdata", in_readdata, 128'hDEADBEEF_00000001_CAFEF00D_12345678);
        tick();
        in_read = 1'b0;
        check("t3_read_dropped", out_read, 1'b0);
        tick();
        check("t3_late_write", out_write, 1'b1);
        check("t3_late_address", out_address, 32'h3000);
        tick();
        check("t3_empty", wb_empty, 1'b1);

        // A read hitting a queued line waits for that write to retire
        out_waitrequest = 1'b1;
        drive_write(32'h2000, {4{32'hB2B2B2B2}}, 16'hFFFF);
        tick();
        in_write   = 1'b0;
        in_read    = 1'b1;
        in_address = 32'h2008;
        tick();
        check("t4_write_first", out_write, 1'b1);
        check("t4_read_held", out_read, 1'b0);
        tick();
        check("t4_read_still_held", out_read, 1'b0);
        check("t4_read_stalled", in_waitrequest, 1'b1);
        out_waitrequest = 1'b0;
        tick();
        out_waitrequest = 1'b1;
        check("t4_no_read_at_retire", out_read, 1'b0);
        check("t4_empty_at_retire", wb_empty, 1'b1);
        tick();
        check("t4_out_read", out_read, 1'b1);
        check("t4_read_address", out_address, 32'h2008);
        out_readdata    = 128'h0123456789ABCDEF_FEDCBA9876543210;
        out_waitrequest = 1'b0;
        #1;
        check("t4_readdata", in_readdata, 128'h0123456789ABCDEF_FEDCBA9876543210);
        tick();
        in_read = 1'b0;
        check("t4_read_dropped", out_read, 1'b0);

        // Asynchronous reset while a write is on the bus with three entries queued
        out_waitrequest = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_write(32'h600 + 32'(k) * 32'h10, {4{32'h600 + 32'(k)}}, 16'hFFFF);
            tick();
        end
        in_write = 1'b0;
        check("t5_count_before_reset", wb_count, 3'd3);
        check("t5_write_before_reset", out_write, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_out_write", out_write, 1'b0);
        check("t5_async_count", wb_count, 3'd0);
        check("t5_async_empty", wb_empty, 1'b1);
        check("t5_async_wait", in_waitrequest, 1'b1);
        tick();
        tick();
        rst_n           = 1'b1;
        out_waitrequest = 1'b0;
        wr_seen         = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (out_write)
                wr_seen++;
        end
        check("t5_no_writes_after_reset", wr_seen, 0);
        check("t5_empty_after_reset", wb_empty, 1'b1);

`ifdef WRBUF_MERGE_EN
        // Two same-line writes collapse into one entry with OR-ed byte lanes
        out_waitrequest = 1'b1;
        drive_write(32'h5000, 128'h000102030405060708090A0B0C0D0E0F, 16'h000F);
        tick();
        drive_write(32'h5000, 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF, 16'hF000);
        #1;
        check("m_merge_accept", in_waitrequest, 1'b0);
        tick();
        in_write = 1'b0;
        check("m_count", wb_count, 3'd1);
        check("m_out_write", out_write, 1'b1);
        check("m_out_be", out_byteenable, 16'hF00F);
        check("m_out_data", out_writedata, 128'hB0B1B2B3_04050607_08090A0B_0C0D0E0F);
        out_waitrequest = 1'b0;
        tick();
        check("m_empty", wb_empty, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
